// File: rtl/pipeline_issue_ctrl.sv
// Round-robin issue controller for a chain of pipeline stages: tags each issue,
// tracks in-flight work and applies stage_offset changes only once the pipeline is empty.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module pipeline_issue_ctrl #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = `ADDRESS_WIDTH,
  parameter int ID_W         = `ID_WIDTH,
  parameter int MAX_INFLIGHT = 15,
  localparam int REQ_IDX_W   = $clog2(NUM_REQ),
  localparam int SEQ_W       = ID_W - REQ_IDX_W,
  localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         pipe_in_address,
  output logic [ID_W-1:0]           pipe_in_id,
  output logic                      pipe_in_valid,
  input  logic                      pipe_stall,
  input  logic                      pipe_out_valid,
  input  logic                      cfg_we,
  input  logic [ADDR_W-1:0]         cfg_offset,
  output logic [ADDR_W-1:0]         stage_offset,
  output logic                      cfg_busy,
  output logic [CNT_W-1:0]          inflight
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_UPDATE} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_latch_cfg;
  logic [REQ_IDX_W-1:0]   r_ptr;
  logic [SEQ_W-1:0]       r_seq [NUM_REQ];
  logic [ADDR_W-1:0]      r_pending;
  logic [ADDR_W-1:0]      w_req_addr [NUM_REQ];
  logic                   w_accept;
  logic                   w_retire;
  logic                   w_slot_open;
  logic                   w_found;
  logic                   w_do_grant;
  logic [REQ_IDX_W-1:0]   w_grant_idx;

  assign w_accept = pipe_in_valid & ~pipe_stall;
  assign w_retire = pipe_out_valid & ~pipe_stall;

  // The registered-but-unaccepted item already occupies one in-flight slot.
  assign w_slot_open = (r_state == S_RUN) && (!pipe_in_valid || !pipe_stall) &&
                       (({1'b0, inflight} + {{CNT_W{1'b0}}, pipe_in_valid}) <
                        (CNT_W+1)'(MAX_INFLIGHT));

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_req_addr[i] = req_address[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    logic [REQ_IDX_W-1:0] v_idx;
    v_idx       = '0;
    w_found     = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = r_ptr + REQ_IDX_W'(k);
      if (!w_found && req_valid[v_idx]) begin
        w_found     = 1'b1;
        w_grant_idx = v_idx;
      end
    end
  end

  assign w_do_grant = w_slot_open & w_found;

  always_comb begin
    req_ready = '0;
    if (w_do_grant && reset) begin
      req_ready[w_grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_in_valid   <= 1'b0;
      pipe_in_address <= '0;
      pipe_in_id      <= '0;
      r_ptr           <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_seq[i] <= '0;
      end
    end else if (w_do_grant) begin
      pipe_in_address      <= w_req_addr[w_grant_idx];
      pipe_in_id           <= {w_grant_idx, r_seq[w_grant_idx]};
      pipe_in_valid        <= 1'b1;
      r_seq[w_grant_idx]   <= r_seq[w_grant_idx] + 1'b1;
      r_ptr                <= w_grant_idx + 1'b1;
    end else if (w_accept) begin
      pipe_in_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
    end else if (w_accept && !w_retire) begin
      inflight <= inflight + 1'b1;
    end else if (!w_accept && w_retire && (inflight != '0)) begin
      inflight <= inflight - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch_cfg = 1'b0;
    unique case (r_state)
      S_RUN: begin
        if (cfg_we) begin
          w_latch_cfg = 1'b1;
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!pipe_in_valid && (inflight == '0)) begin
          w_state_nxt = S_UPDATE;
        end
      end
      S_UPDATE: w_state_nxt = S_RUN;
      default:  w_state_nxt = S_RUN;
    endcase
  end

  // Further cfg_we pulses are ignored until the pending offset has been applied.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending    <= '0;
      stage_offset <= '0;
      cfg_busy     <= 1'b0;
    end else begin
      if (w_latch_cfg) begin
        r_pending <= cfg_offset;
        cfg_busy  <= 1'b1;
      end
      if (r_state == S_UPDATE) begin
        stage_offset <= r_pending;
        cfg_busy     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// Bench for pipeline_issue_ctrl: behavioural reference checked every cycle,
// plus directed scenarios with hand-derived literal expectations.
module tb_pipeline_issue_ctrl;
  localparam int NUM_REQ      = 4;
  localparam int ADDR_W       = 16;
  localparam int ID_W         = 6;
  localparam int MAX_INFLIGHT = 15;
  localparam int SEQ_W        = 4;
  localparam int CNT_W        = 4;

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_address = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]         pipe_in_address;
  logic [ID_W-1:0]           pipe_in_id;
  logic                      pipe_in_valid;
  logic                      pipe_stall = 1'b0;
  logic                      pipe_out_valid = 1'b0;
  logic                      cfg_we = 1'b0;
  logic [ADDR_W-1:0]         cfg_offset = '0;
  logic [ADDR_W-1:0]         stage_offset;
  logic                      cfg_busy;
  logic [CNT_W-1:0]          inflight;

  pipeline_issue_ctrl #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .ID_W(ID_W), .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_address(req_address),
    .req_ready(req_ready), .pipe_in_address(pipe_in_address), .pipe_in_id(pipe_in_id),
    .pipe_in_valid(pipe_in_valid), .pipe_stall(pipe_stall), .pipe_out_valid(pipe_out_valid),
    .cfg_we(cfg_we), .cfg_offset(cfg_offset), .stage_offset(stage_offset),
    .cfg_busy(cfg_busy), .inflight(inflight)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an issue register, a count of outstanding work, per-requester
  // sequence numbers and a pending-offset flag with a one-cycle apply step.
  int m_vld, m_addr, m_id, m_ptr, m_inflight;
  int m_busy, m_apply, m_pending, m_offset;
  int m_seq [NUM_REQ];

  task automatic model_reset();
    m_vld = 0; m_addr = 0; m_id = 0; m_ptr = 0; m_inflight = 0;
    m_busy = 0; m_apply = 0; m_pending = 0; m_offset = 0;
    for (int i = 0; i < NUM_REQ; i++) m_seq[i] = 0;
  endtask

  initial model_reset();

  int c_g, c_open, c_acc, c_ret, c_drained, c_old_inf;
  int c_exp_ready;

  always @(negedge clk) begin
    if (!reset) begin
      model_reset();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_valid", pipe_in_valid, 0);
      chk("rst_addr", pipe_in_address, 0);
      chk("rst_id", pipe_in_id, 0);
      chk("rst_offset", stage_offset, 0);
      chk("rst_busy", cfg_busy, 0);
      chk("rst_inflight", inflight, 0);
    end else begin
      c_open = (m_busy == 0) && (m_vld == 0 || !pipe_stall) &&
               (m_inflight + m_vld < MAX_INFLIGHT);
      c_g = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (c_g < 0 && req_valid[(m_ptr + k) % NUM_REQ]) c_g = (m_ptr + k) % NUM_REQ;
      end
      c_exp_ready = (c_open && c_g >= 0) ? (1 << c_g) : 0;
      chk("req_ready", req_ready, c_exp_ready);
      chk("pipe_in_valid", pipe_in_valid, m_vld);
      chk("pipe_in_id", pipe_in_id, m_id);
      chk("pipe_in_address", pipe_in_address, m_addr);
      chk("stage_offset", stage_offset, m_offset);
      chk("cfg_busy", cfg_busy, m_busy);
      chk("inflight", inflight, m_inflight);

      c_acc = (m_vld != 0) && !pipe_stall;
      c_ret = pipe_out_valid && !pipe_stall;
      c_drained = (m_busy != 0) && (m_apply == 0) && (m_vld == 0) && (m_inflight == 0);
      c_old_inf = m_inflight;
      if (c_open && c_g >= 0) begin
        m_addr = int'(req_address[c_g*ADDR_W +: ADDR_W]);
        m_id = c_g * (1 << SEQ_W) + m_seq[c_g];
        m_vld = 1;
        m_seq[c_g] = (m_seq[c_g] + 1) % (1 << SEQ_W);
        m_ptr = (c_g + 1) % NUM_REQ;
      end else if (c_acc) begin
        m_vld = 0;
      end
      m_inflight = c_old_inf + c_acc - ((c_ret && c_old_inf > 0) ? 1 : 0);
      if (m_apply != 0) begin
        m_offset = m_pending; m_busy = 0; m_apply = 0;
      end else if (c_drained) begin
        m_apply = 1;
      end else if (m_busy == 0 && cfg_we) begin
        m_pending = int'(cfg_offset); m_busy = 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; req_valid = '0; pipe_stall = 1'b0; pipe_out_valid = 1'b0; cfg_we = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    req_valid = '0; pipe_stall = 1'b0; cfg_we = 1'b0;
    while ((m_inflight > 0 || m_vld != 0) && n < 100) begin
      pipe_out_valid = (m_inflight > 0);
      cyc();
      n++;
    end
    pipe_out_valid = 1'b0;
    chk("drain_bound", n < 100, 1);
  endtask

  int grants;
  int n;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held: grants must stay off even with every request raised.
    req_valid = 4'b1111;
    repeat (3) cyc();
    #1 chk("lit_ready_in_reset", req_ready, 0);
    req_valid = '0;
    reset = 1'b1;

    // Single requester, two back-to-back issues then two retires.
    req_valid = 4'b0001;
    req_address[15:0] = 16'h0010;
    #1 chk("lit_single_ready", req_ready, 4'b0001);
    cyc();
    chk("lit_single_valid", pipe_in_valid, 1);
    chk("lit_single_id0", pipe_in_id, 0);
    chk("lit_single_addr0", pipe_in_address, 16'h0010);
    req_address[15:0] = 16'h0011;
    cyc();
    chk("lit_single_id1", pipe_in_id, 1);
    chk("lit_single_addr1", pipe_in_address, 16'h0011);
    chk("lit_single_inflight1", inflight, 1);
    req_valid = '0;
    cyc();
    chk("lit_single_inflight2", inflight, 2);
    chk("lit_single_idle", pipe_in_valid, 0);
    pipe_out_valid = 1'b1;
    cyc();
    chk("lit_single_retire1", inflight, 1);
    cyc();
    chk("lit_single_retire2", inflight, 0);
    pipe_out_valid = 1'b0;

    // Fairness: everyone requesting continuously.
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1 chk("lit_fair_ready", req_ready, 1 << (k % 4));
      cyc();
      chk("lit_fair_id", pipe_in_id, (k % 4) * 16 + k / 4);
    end
    drain();

    // Stall holds the registered item for three cycles.
    do_reset();
    req_valid = 4'b0001;
    req_address[15:0] = 16'h0020;
    cyc();
    pipe_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lit_stall_ready", req_ready, 0);
      chk("lit_stall_valid", pipe_in_valid, 1);
      chk("lit_stall_addr", pipe_in_address, 16'h0020);
      chk("lit_stall_id", pipe_in_id, 0);
      cyc();
    end
    pipe_stall = 1'b0;
    req_valid = '0;
    chk("lit_stall_not_yet", inflight, 0);
    cyc();
    chk("lit_stall_accepted", inflight, 1);
    chk("lit_stall_no_dup", pipe_in_valid, 0);
    drain();

    // In-flight limit.
    do_reset();
    req_valid = 4'b1111;
    grants = 0;
    for (int k = 0; k < 20; k++) begin
      #1 if (req_ready != 0) grants++;
      cyc();
    end
    chk("lit_limit_grants", grants, 15);
    chk("lit_limit_inflight", inflight, 15);
    pipe_out_valid = 1'b1;
    cyc();
    pipe_out_valid = 1'b0;
    grants = 0;
    for (int k = 0; k < 5; k++) begin
      #1 if (req_ready != 0) grants++;
      cyc();
    end
    chk("lit_limit_reopen", grants, 1);
    chk("lit_limit_refill", inflight, 15);
    drain();

    // Offset change with three items in flight; second pulse ignored.
    do_reset();
    req_valid = 4'b0001;
    repeat (3) cyc();
    req_valid = '0;
    cyc();
    chk("lit_cfg_inflight3", inflight, 3);
    cfg_we = 1'b1; cfg_offset = 16'h0004;
    cyc();
    cfg_we = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("lit_cfg_busy", cfg_busy, 1);
    chk("lit_cfg_no_grant", req_ready, 0);
    cyc();
    cfg_we = 1'b1; cfg_offset = 16'h0008;
    cyc();
    cfg_we = 1'b0;
    pipe_out_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("lit_cfg_offset_held", stage_offset, 0);
      cyc();
    end
    pipe_out_valid = 1'b0;
    n = 0;
    while (cfg_busy && n < 10) begin
      cyc();
      n++;
    end
    chk("lit_cfg_apply_cycles", n, 2);
    chk("lit_cfg_offset", stage_offset, 16'h0004);
    #1 chk("lit_cfg_resume", req_ready, 4'b0010);
    cyc();
    chk("lit_cfg_resume_id", pipe_in_id, 16);
    drain();

    // Async reset in the middle of a drain.
    do_reset();
    req_valid = 4'b0011;
    repeat (2) cyc();
    req_valid = '0;
    cyc();
    cfg_we = 1'b1; cfg_offset = 16'h000C;
    cyc();
    cfg_we = 1'b0;
    req_valid = 4'b1111;
    cyc();
    chk("lit_rst_pre_inflight", inflight, 2);
    chk("lit_rst_pre_busy", cfg_busy, 1);
    reset = 1'b0;
    #1;
    chk("lit_rst_now_inflight", inflight, 0);
    chk("lit_rst_now_busy", cfg_busy, 0);
    chk("lit_rst_now_ready", req_ready, 0);
    chk("lit_rst_now_valid", pipe_in_valid, 0);
    cyc();
    reset = 1'b1;
    #1 chk("lit_rst_first_ready", req_ready, 4'b0001);
    cyc();
    chk("lit_rst_first_id", pipe_in_id, 0);
    chk("lit_rst_offset", stage_offset, 0);
    drain();

    // Randomised traffic against the reference.
    for (int k = 0; k < 3000; k++) begin
      req_valid = NUM_REQ'($urandom);
      req_address = {$urandom, $urandom};
      pipe_stall = ($urandom % 4) == 0;
      pipe_out_valid = (m_inflight > 0) && (((k / 200) % 2 == 0) ? ($urandom % 4 != 0)
                                                                  : ($urandom % 4 == 0));
      cfg_we = ($urandom % 32) == 0;
      cfg_offset = ADDR_W'($urandom);
      cyc();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
